seq_carry_skip_adder: RTL and testbench
=======================================

SEQ_CARRY_SKIP_ADDER -- requirements
Module: seq_carry_skip_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter BLOCK, default 4, carry-skip block size in bits; it SHALL divide WIDTH evenly.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock in the block.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle command strobe; honoured only in IDLE.
REQ-006 SHALL have port mode  input  2  operation, sampled with start: 00 ADD, 01 SUB, 10 ACC (R+B), 11 ACC_SUB (R-B).
REQ-007 SHALL have port in_valid  input  1  in_data holds a valid operand byte.
REQ-008 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-009 SHALL have port in_data  input  8  operand byte, least-significant byte first.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid result byte.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 SHALL have port out_data  output  8  result byte, least-significant byte first.
REQ-013 SHALL have port carry_out  output  1  carry of the final block, valid while out_valid=1.
REQ-014 SHALL have port overflow  output  1  signed overflow of the final result, valid while out_valid=1.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, LOAD_A, LOAD_B, COMPUTE, OUT.
REQ-017 In IDLE, start=1 SHALL latch mode and go to LOAD_A (ADD/SUB) or LOAD_B (ACC/ACC_SUB); start in any other state SHALL be ignored.
REQ-018 A byte SHALL be transferred on each cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD_A and LOAD_B.
REQ-019 LOAD_A SHALL accept WIDTH/8 bytes into A, then go to LOAD_B; LOAD_B SHALL accept WIDTH/8 bytes into B, then go to COMPUTE.
REQ-020 In ACC modes, operand A SHALL be the accumulator R, which holds the last completed result.
REQ-021 For SUB and ACC_SUB, B SHALL be inverted and the initial carry-in SHALL be 1; otherwise the carry-in SHALL be 0.
REQ-022 COMPUTE SHALL process one BLOCK-bit slice per cycle, LSB slice first, taking exactly WIDTH/BLOCK cycles.
REQ-023 Each slice SHALL compute propagate P = AND of (a XOR b) across the slice; if P=1 the slice carry-out SHALL equal its carry-in (skip path), else the ripple carry-out.
REQ-024 Sum bits SHALL be (a XOR b XOR ripple carry) for every slice, whether or not the skip path is taken.
REQ-025 After the last slice, R SHALL be updated with the sum, carry_out with the final carry, and overflow with the XOR of the carries into and out of the MSB; the state SHALL then go to OUT.
REQ-026 OUT SHALL present the WIDTH/8 result bytes LSB first, advancing one byte per out_valid and out_ready handshake; after the last byte, the state SHALL return to IDLE.
REQ-027 out_data, carry_out and overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 in_valid=0 during a load phase SHALL stall without losing previously accepted bytes.
REQ-029 Arithmetic SHALL wrap modulo 2^WIDTH: no saturation, and carry_out is reported only.
REQ-030 Latency from the last B byte accepted to the first out_valid SHALL be WIDTH/BLOCK+1 cycles.

Reset
REQ-031 While rst_n=0, the state SHALL be IDLE and R, A, B, the byte counters, the slice counter, carry_out, overflow, out_data, out_valid and in_ready SHALL all be 0.
REQ-032 Reset asserted during any state SHALL abort the operation immediately; partial operands and partial results SHALL be discarded and R SHALL be cleared.
REQ-033 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-034 WIDTH=16, BLOCK=4: ADD with A=0x1234, B=0x0FFF -> out bytes 0x33, 0x22; carry_out=0; overflow=0; first out_valid 5 cycles after the last B byte.
REQ-035 ADD with A=0xFFFF, B=0x0001 (full skip chain) -> out 0x00, 0x00; carry_out=1; overflow=0.
REQ-036 SUB with A=0x8000, B=0x0001 -> out 0xFF, 0x7F; carry_out=1; overflow=1.
REQ-037 ADD 0x0005+0x0003, then ACC with B=0x0010 -> second result 0x0018; only 2 input bytes are accepted for the ACC command.
REQ-038 Randomised in_valid and out_ready gaps over 1000 random ADD/SUB operations -> every result equals the reference (A±B) mod 2^16; start pulses issued while busy are ignored.
REQ-039 rst_n pulsed low mid-COMPUTE -> busy=0 and out_valid=0 immediately; a subsequent ACC with B=0x0001 -> result 0x0001.

Source files
------------

// File: rtl/seq_carry_skip_adder.sv
// Byte-serial adder/subtractor with a carry-skip datapath that
// evaluates one BLOCK-bit slice per cycle and keeps an accumulator.
module seq_carry_skip_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       carry_out,
   output logic       overflow,
   output logic       busy
);

   localparam int NBYTES = WIDTH / 8;
   localparam int NSL    = WIDTH / BLOCK;
   localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int SCW    = (NSL > 1) ? $clog2(NSL) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_COMPUTE,
      S_OUT
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_mode;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_sum;
   logic [BCW-1:0]   r_byte_cnt;
   logic [SCW-1:0]   r_slice_cnt;
   logic             r_carry;
   logic             r_carry_out;
   logic             r_overflow;

   logic             w_byte_last;
   logic             w_slice_last;
   logic             w_in_fire;
   logic             w_out_fire;
   int               w_by_sh;
   int               w_sl_sh;
   logic [WIDTH-1:0] w_byte_ins;
   logic [WIDTH-1:0] w_byte_mask;
   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_opb;
   logic [WIDTH-1:0] w_sl_mask;
   logic [WIDTH-1:0] w_sum_new;
   logic [BLOCK-1:0] w_a_sl;
   logic [BLOCK-1:0] w_b_sl;
   logic [BLOCK-1:0] w_x;
   logic [BLOCK-1:0] w_s;
   logic [BLOCK:0]   w_c;
   logic             w_p;
   logic             w_cout;

   assign w_byte_last  = (r_byte_cnt == BCW'(NBYTES - 1));
   assign w_slice_last = (r_slice_cnt == SCW'(NSL - 1));
   assign w_in_fire    = in_valid & in_ready;
   assign w_out_fire   = out_valid & out_ready;
   assign w_by_sh      = int'(r_byte_cnt) * 8;
   assign w_sl_sh      = int'(r_slice_cnt) * BLOCK;

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start)
               w_next = mode[1] ? S_LOAD_B : S_LOAD_A;
         end
         S_LOAD_A: begin
            in_ready = 1'b1;
            if (w_in_fire && w_byte_last)
               w_next = S_LOAD_B;
         end
         S_LOAD_B: begin
            in_ready = 1'b1;
            if (w_in_fire && w_byte_last)
               w_next = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (w_slice_last)
               w_next = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (w_out_fire && w_byte_last)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_byte_ins  = WIDTH'(in_data) << w_by_sh;
   assign w_byte_mask = WIDTH'(8'hFF) << w_by_sh;

   // One carry-skip slice; the skip mux only steers the carry chain,
   // sum bits always come from the ripple carries.
   always_comb begin
      w_opa     = r_mode[1] ? r_r : r_a;
      w_opb     = r_mode[0] ? ~r_b : r_b;
      w_a_sl    = BLOCK'(w_opa >> w_sl_sh);
      w_b_sl    = BLOCK'(w_opb >> w_sl_sh);
      w_x       = '0;
      w_s       = '0;
      w_c       = '0;
      w_c[0]    = r_carry;
      for (int i = 0; i < BLOCK; i++) begin
         w_x[i]   = w_a_sl[i] ^ w_b_sl[i];
         w_s[i]   = w_x[i] ^ w_c[i];
         w_c[i+1] = (w_a_sl[i] & w_b_sl[i]) | (w_x[i] & w_c[i]);
      end
      w_p       = &w_x;
      w_cout    = w_p ? r_carry : w_c[BLOCK];
      w_sl_mask = WIDTH'({BLOCK{1'b1}}) << w_sl_sh;
      w_sum_new = (r_sum & ~w_sl_mask) | (WIDTH'(w_s) << w_sl_sh);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mode      <= 2'b00;
         r_a         <= '0;
         r_b         <= '0;
         r_r         <= '0;
         r_sum       <= '0;
         r_byte_cnt  <= '0;
         r_slice_cnt <= '0;
         r_carry     <= 1'b0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode      <= mode;
                  r_carry     <= mode[0];
                  r_byte_cnt  <= '0;
                  r_slice_cnt <= '0;
                  r_sum       <= '0;
               end
            end
            S_LOAD_A: begin
               if (w_in_fire) begin
                  r_a        <= (r_a & ~w_byte_mask) | w_byte_ins;
                  r_byte_cnt <= w_byte_last ? '0 : r_byte_cnt + 1'b1;
               end
            end
            S_LOAD_B: begin
               if (w_in_fire) begin
                  r_b        <= (r_b & ~w_byte_mask) | w_byte_ins;
                  r_byte_cnt <= w_byte_last ? '0 : r_byte_cnt + 1'b1;
               end
            end
            S_COMPUTE: begin
               r_sum   <= w_sum_new;
               r_carry <= w_cout;
               if (w_slice_last) begin
                  r_slice_cnt <= '0;
                  r_r         <= w_sum_new;
                  r_carry_out <= w_cout;
                  r_overflow  <= w_c[BLOCK-1] ^ w_cout;
               end else begin
                  r_slice_cnt <= r_slice_cnt + 1'b1;
               end
            end
            S_OUT: begin
               if (w_out_fire)
                  r_byte_cnt <= w_byte_last ? '0 : r_byte_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out_data  = out_valid ? 8'(r_r >> w_by_sh) : 8'h00;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_carry_skip_adder.sv
// Directed and randomised checks for seq_carry_skip_adder,
// WIDTH=16, BLOCK=4.
module tb_seq_carry_skip_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       carry_out;
   logic       overflow;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int n_acc = 0;

   always #5 clk = ~clk;

   seq_carry_skip_adder #(.WIDTH(16), .BLOCK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .carry_out (carry_out),
      .overflow  (overflow),
      .busy      (busy)
   );

   always @(posedge clk)
      if (in_valid && in_ready) n_acc++;

   typedef struct {
      logic [1:0]  m;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        c;
      logic        v;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timeout got none expected handshake", nm);
   endtask

   task automatic do_op(input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] b, input bit gaps,
                        output logic [15:0] res, output logic c,
                        output logic v, output int lat);
      logic [7:0] bytes[4];
      int         nb;
      int         guard;
      bit         acc;
      bit         got;
      bit         stall_prev;
      logic [7:0] prev;
      res = '0; c = 1'b0; v = 1'b0; lat = 0;
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
      nb = 0;
      if (!m[1]) begin
         bytes[0] = a[7:0]; bytes[1] = a[15:8]; nb = 2;
      end
      bytes[nb] = b[7:0]; bytes[nb+1] = b[15:8]; nb += 2;
      for (int i = 0; i < nb; i++) begin
         in_data = bytes[i];
         guard = 0;
         do begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start    = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
            mode     = 2'($urandom);
            acc      = in_valid && in_ready;
            tick();
            guard++;
         end while (!acc && guard < 200);
         if (!acc) begin
            in_valid = 1'b0; start = 1'b0;
            timeout("load");
            return;
         end
      end
      in_valid = 1'b0;
      start = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         start = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
         tick();
         lat++;
      end
      start = 1'b0;
      if (!out_valid) begin
         timeout("compute");
         return;
      end
      stall_prev = 1'b0;
      prev = 8'h00;
      for (int i = 0; i < 2; i++) begin
         guard = 0;
         do begin
            if (stall_prev && out_valid)
               chk("hold_data", out_data, prev);
            out_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start     = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
            got        = out_valid && out_ready;
            stall_prev = out_valid && !out_ready;
            prev       = out_data;
            if (got) begin
               res[i*8 +: 8] = out_data;
               c = carry_out;
               v = overflow;
            end
            tick();
            guard++;
         end while (!got && guard < 200);
         stall_prev = 1'b0;
         if (!got) begin
            out_ready = 1'b0; start = 1'b0;
            timeout("output");
            return;
         end
      end
      out_ready = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      logic [15:0] res;
      logic [15:0] ref_r;
      logic        c;
      logic        v;
      int          lat;
      int          n0;
      logic [1:0]  m;
      logic [15:0] a;
      logic [15:0] b;

      tbl[0] = '{2'b00, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
      tbl[1] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
      tbl[3] = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      tbl[4] = '{2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
      tbl[5] = '{2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      tbl[6] = '{2'b00, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
      tbl[7] = '{2'b10, 16'h0000, 16'h0010, 16'h0018, 1'b0, 1'b0};
      tbl[8] = '{2'b11, 16'h0000, 16'h0008, 16'h0010, 1'b1, 1'b0};
      tbl[9] = '{2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};

      #1;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_ovf", overflow, 0);
      repeat (2) tick();
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         n0 = n_acc;
         do_op(tbl[i].m, tbl[i].a, tbl[i].b, 1'b0, res, c, v, lat);
         chk($sformatf("vec%0d_result", i), res, tbl[i].r);
         chk($sformatf("vec%0d_carry", i), c, tbl[i].c);
         chk($sformatf("vec%0d_ovf", i), v, tbl[i].v);
         chk($sformatf("vec%0d_latency", i), lat, 5);
         chk($sformatf("vec%0d_bytes", i), n_acc - n0,
             tbl[i].m[1] ? 2 : 4);
         chk($sformatf("vec%0d_idle", i), busy, 0);
      end

      for (int k = 0; k < 1000; k++) begin
         m = {1'b0, 1'($urandom)};
         a = 16'($urandom);
         b = 16'($urandom);
         ref_r = m[0] ? a - b : a + b;
         do_op(m, a, b, 1'b1, res, c, v, lat);
         chk($sformatf("rand%0d_a%0h_b%0h_m%0d", k, a, b, m), res, ref_r);
      end

      start = 1'b1;
      mode  = 2'b00;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAB;
      repeat (4) tick();
      in_valid = 1'b0;
      tick();
      chk("mid_compute_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      tick();
      rst_n = 1'b1;
      do_op(2'b10, 16'h0000, 16'h0001, 1'b0, res, c, v, lat);
      chk("acc_after_reset", res, 16'h0001);
      chk("acc_after_reset_carry", c, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
